// File: rtl/armleocpu_load_tracker_pkg.sv
// Shared definitions for the load tracker: load type encodings (funct3),
// result status codes, the queue entry layout and the status priority helper.
package armleocpu_load_tracker_pkg;

   localparam logic [2:0] LOAD_BYTE          = 3'b000;
   localparam logic [2:0] LOAD_HALF          = 3'b001;
   localparam logic [2:0] LOAD_WORD          = 3'b010;
   localparam logic [2:0] LOAD_BYTE_UNSIGNED = 3'b100;
   localparam logic [2:0] LOAD_HALF_UNSIGNED = 3'b101;

   localparam logic [1:0] LOADERR_NONE       = 2'b00;
   localparam logic [1:0] LOADERR_MISALIGNED = 2'b01;
   localparam logic [1:0] LOADERR_UNKNOWN    = 2'b10;
   localparam logic [1:0] LOADERR_FAULT      = 2'b11;

   typedef struct packed {
      logic [2:0]  ltype;
      logic [1:0]  offset;
      logic        done;
      logic [1:0]  err;
      logic [31:0] data;
   } load_entry_t;

   // Unknown type wins over misaligned.
   function automatic logic [1:0] load_err_code(input logic missaligned,
                                                input logic unknowntype);
      if (unknowntype)      return LOADERR_UNKNOWN;
      else if (missaligned) return LOADERR_MISALIGNED;
      else                  return LOADERR_NONE;
   endfunction

endpackage

// File: rtl/armleocpu_load_tracker_loadgen.sv
// armleocpu_loadgen: combinational load aligner/classifier.
//   offset      byte offset within the word
//   ltype       load type (funct3)
//   word        raw 32-bit read word
//   data        word shifted right by offset*8, then sign/zero extended
//   missaligned LW with offset!=0, or LH/LHU with odd offset
//   unknowntype funct3 011, 110, 111
module armleocpu_loadgen
   import armleocpu_load_tracker_pkg::*;
(
   input  logic [1:0]  offset,
   input  logic [2:0]  ltype,
   input  logic [31:0] word,
   output logic [31:0] data,
   output logic        missaligned,
   output logic        unknowntype
);

   logic [31:0] shifted;

   assign shifted = word >> {offset, 3'b000};

   always_comb begin
      data        = '0;
      missaligned = 1'b0;
      unknowntype = 1'b0;
      case (ltype)
         LOAD_BYTE:          data = {{24{shifted[7]}}, shifted[7:0]};
         LOAD_BYTE_UNSIGNED: data = {24'd0, shifted[7:0]};
         LOAD_HALF: begin
            data        = {{16{shifted[15]}}, shifted[15:0]};
            missaligned = offset[0];
         end
         LOAD_HALF_UNSIGNED: begin
            data        = {16'd0, shifted[15:0]};
            missaligned = offset[0];
         end
         LOAD_WORD: begin
            data        = shifted;
            missaligned = (offset != 2'd0);
         end
         default:            unknowntype = 1'b1;
      endcase
   end

endmodule

// File: rtl/armleocpu_load_tracker.sv
// armleocpu_load_tracker: in-order queue of outstanding loads.
//   req_*  : load request from execute (offset, type, tag); req_error flags
//            requests that are retired with an error and need no memory read
//   mem_*  : in-order read responses, no backpressure
//   rsp_*  : aligned result to writeback, valid/ready handshake
// Entries are written at the tail, filled in order by memory responses and
// retired from the head once done.
module armleocpu_load_tracker
   import armleocpu_load_tracker_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_offset,
   input  logic [2:0]       req_type,
   input  logic [TAG_W-1:0] req_tag,
   output logic             req_error,
   input  logic             mem_rvalid,
   input  logic [31:0]      mem_rdata,
   input  logic             mem_rerr,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_data,
   output logic [TAG_W-1:0] rsp_tag,
   output logic [1:0]       rsp_err
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   load_entry_t      ent_q [DEPTH];
   load_entry_t      ent_d [DEPTH];
   logic [TAG_W-1:0] tag_q [DEPTH];
   logic [TAG_W-1:0] tag_d [DEPTH];

   logic        accept, retire;
   logic        req_mis, req_unk;
   logic [31:0] req_gen_data;
   logic [1:0]  req_err_code;

   logic          fill_found;
   logic [PW-1:0] fill_idx, scan_idx;
   logic [1:0]    fill_offset;
   logic [2:0]    fill_type;
   logic [31:0]   fill_data;
   logic          fill_mis, fill_unk;

   // Request path: word tied to zero, so the extracted value is the zero
   // stored into entries that never see a memory response.
   armleocpu_loadgen u_req_gen (
      .offset      (req_offset),
      .ltype       (req_type),
      .word        (32'd0),
      .data        (req_gen_data),
      .missaligned (req_mis),
      .unknowntype (req_unk)
   );

   assign req_error    = req_mis || req_unk;
   assign req_err_code = load_err_code(req_mis, req_unk);
   assign req_ready    = (count_q != CW'(DEPTH));

   // Oldest live entry still waiting for data; only registered entries are
   // eligible, so a response never fills a same-cycle request.
   always_comb begin
      fill_found = 1'b0;
      fill_idx   = head_q;
      scan_idx   = head_q;
      for (int i = 0; i < DEPTH; i++) begin
         scan_idx = head_q + PW'(i);
         if (!fill_found && (CW'(i) < count_q) && !ent_q[scan_idx].done) begin
            fill_found = 1'b1;
            fill_idx   = scan_idx;
         end
      end
   end

   assign fill_offset = ent_q[fill_idx].offset;
   assign fill_type   = ent_q[fill_idx].ltype;

   armleocpu_loadgen u_fill_gen (
      .offset      (fill_offset),
      .ltype       (fill_type),
      .word        (mem_rdata),
      .data        (fill_data),
      .missaligned (fill_mis),
      .unknowntype (fill_unk)
   );

   assign rsp_valid = (count_q != '0) && ent_q[head_q].done;
   assign rsp_data  = rsp_valid ? ent_q[head_q].data : '0;
   assign rsp_tag   = rsp_valid ? tag_q[head_q] : '0;
   assign rsp_err   = rsp_valid ? ent_q[head_q].err : LOADERR_NONE;

   assign accept = req_valid && req_ready;
   assign retire = rsp_valid && rsp_ready;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      ent_d   = ent_q;
      tag_d   = tag_q;

      if (accept) begin
         tag_d[tail_q]        = req_tag;
         ent_d[tail_q].ltype  = req_type;
         ent_d[tail_q].offset = req_offset;
         ent_d[tail_q].done   = req_error;
         ent_d[tail_q].err    = req_err_code;
         ent_d[tail_q].data   = req_gen_data;
         tail_d               = tail_q + PW'(1);
      end

      if (mem_rvalid && fill_found) begin
         ent_d[fill_idx].done = 1'b1;
         // Pending entries always classify clean; only the fault matters.
         ent_d[fill_idx].err  = mem_rerr ? LOADERR_FAULT : load_err_code(fill_mis, fill_unk);
         ent_d[fill_idx].data = mem_rerr ? 32'd0 : fill_data;
      end

      if (retire) begin
         head_d = head_q + PW'(1);
      end

      count_d = count_q + CW'(accept) - CW'(retire);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
            tag_q[i] <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         ent_q   <= ent_d;
         tag_q   <= tag_d;
      end
   end

endmodule

// File: tb/tb_armleocpu_load_tracker.sv
// Self-checking bench for armleocpu_load_tracker: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_armleocpu_load_tracker;

   localparam int DEPTH = 2;
   localparam int TAG_W = 5;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_offset;
   logic [2:0]       req_type;
   logic [TAG_W-1:0] req_tag;
   logic             req_error;
   logic             mem_rvalid;
   logic [31:0]      mem_rdata;
   logic             mem_rerr;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [31:0]      rsp_data;
   logic [TAG_W-1:0] rsp_tag;
   logic [1:0]       rsp_err;

   armleocpu_load_tracker #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_offset (req_offset),
      .req_type   (req_type),
      .req_tag    (req_tag),
      .req_error  (req_error),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .mem_rerr   (mem_rerr),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_tag    (rsp_tag),
      .rsp_err    (rsp_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [2:0]       ty;
      logic [1:0]       off;
      bit               done;
      logic [1:0]       err;
      logic [31:0]      data;
   } ment_t;

   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [31:0]      data;
      logic [1:0]       err;
   } rec_t;

   ment_t mq[$];
   rec_t  got_q[$];
   int    n_checks = 0;
   int    n_err = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] m_err(input logic [2:0] ty, input logic [1:0] off);
      int t, o;
      t = int'(ty);
      o = int'(off);
      if (t == 3 || t == 6 || t == 7) return 2'd2;
      if (t == 2 && o != 0) return 2'd1;
      if ((t == 1 || t == 5) && (o % 2 == 1)) return 2'd1;
      return 2'd0;
   endfunction

   function automatic logic [31:0] m_data(input logic [2:0] ty, input logic [1:0] off,
                                          input logic [31:0] w);
      int unsigned v;
      v = w >> (int'(off) * 8);
      case (int'(ty))
         0: begin v = v % 256;   if (v >= 128)   v = v + 32'hFFFF_FF00; end
         4: v = v % 256;
         1: begin v = v % 65536; if (v >= 32768) v = v + 32'hFFFF_0000; end
         5: v = v % 65536;
         default: ;
      endcase
      return v;
   endfunction

   task automatic drive(input logic v, input logic [1:0] off, input logic [2:0] ty,
                        input logic [TAG_W-1:0] tg, input logic mv, input logic [31:0] md,
                        input logic me, input logic rr);
      req_valid  = v;
      req_offset = off;
      req_type   = ty;
      req_tag    = tg;
      mem_rvalid = mv;
      mem_rdata  = md;
      mem_rerr   = me;
      rsp_ready  = rr;
   endtask

   task automatic idle(input logic rr);
      drive(1'b0, 2'd0, 3'd0, '0, 1'b0, 32'd0, 1'b0, rr);
   endtask

   task automatic check_outputs();
      bit m_valid;
      m_valid = (mq.size() > 0) && mq[0].done;
      check("req_ready", req_ready, mq.size() < DEPTH);
      check("rsp_valid", rsp_valid, m_valid);
      if (m_valid) begin
         check("rsp_tag",  rsp_tag,  mq[0].tag);
         check("rsp_data", rsp_data, mq[0].data);
         check("rsp_err",  rsp_err,  mq[0].err);
      end
   endtask

   // One clock: inputs must already be driven; advances model and DUT together.
   task automatic step();
      int         fi;
      bit         acc, ret;
      logic [1:0] e;
      rec_t       r;
      ment_t      n;
      #1;
      e = m_err(req_type, req_offset);
      if (req_valid) check("req_error", req_error, e != 2'd0);
      acc = req_valid && (mq.size() < DEPTH);
      ret = (mq.size() > 0) && mq[0].done && rsp_ready;
      if (rsp_valid && rsp_ready) begin
         r.tag = rsp_tag; r.data = rsp_data; r.err = rsp_err;
         got_q.push_back(r);
      end
      fi = -1;
      for (int i = 0; i < mq.size(); i++) begin
         if (!mq[i].done) begin fi = i; break; end
      end
      @(posedge clk);
      #1;
      if (mem_rvalid && fi >= 0) begin
         mq[fi].done = 1'b1;
         mq[fi].err  = mem_rerr ? 2'd3 : 2'd0;
         mq[fi].data = mem_rerr ? 32'd0 : m_data(mq[fi].ty, mq[fi].off, mem_rdata);
      end
      if (ret) void'(mq.pop_front());
      if (acc) begin
         n.tag = req_tag; n.ty = req_type; n.off = req_offset;
         n.done = (e != 2'd0); n.err = e; n.data = 32'd0;
         mq.push_back(n);
      end
      check_outputs();
   endtask

   task automatic load_one(input string name, input logic [2:0] ty, input logic [1:0] off,
                           input logic [31:0] word, input logic [31:0] exp_data,
                           input logic [1:0] exp_err);
      drive(1'b1, off, ty, 5'd9, 1'b0, 32'd0, 1'b0, 1'b1);
      step();
      idle(1'b1);
      if (exp_err == 2'd0) begin
         mem_rvalid = 1'b1;
         mem_rdata  = word;
         step();
         idle(1'b1);
      end
      check({name, "_valid"}, rsp_valid, 1'b1);
      check({name, "_data"},  rsp_data,  exp_data);
      check({name, "_err"},   rsp_err,   exp_err);
      step();
   endtask

   initial begin
      rst_n = 1'b0;
      idle(1'b1);
      #12;
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_data",  rsp_data,  32'd0);
      check("rst_rsp_tag",   rsp_tag,   '0);
      check("rst_rsp_err",   rsp_err,   2'd0);
      check("rst_req_ready", req_ready, 1'b1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Extraction and classification.
      load_one("lb_off3",  3'b000, 2'd3, 32'h80AA_BBCC, 32'hFFFF_FF80, 2'd0);
      load_one("lbu_off3", 3'b100, 2'd3, 32'h80AA_BBCC, 32'h0000_0080, 2'd0);
      load_one("lh_off2",  3'b001, 2'd2, 32'h1234_5678, 32'h0000_1234, 2'd0);
      load_one("lh_off1",  3'b001, 2'd1, 32'h0,         32'h0,         2'd1);
      load_one("lw_off2",  3'b010, 2'd2, 32'h0,         32'h0,         2'd1);
      load_one("type011",  3'b011, 2'd0, 32'h0,         32'h0,         2'd2);

      // Ordering around an erroring entry.
      got_q.delete();
      drive(1'b1, 2'd0, 3'b010, 5'd1, 1'b0, 32'd0, 1'b0, 1'b1); step();
      drive(1'b1, 2'd1, 3'b001, 5'd2, 1'b0, 32'd0, 1'b0, 1'b1); step();
      drive(1'b0, 2'd0, 3'b000, 5'd0, 1'b1, 32'h11, 1'b0, 1'b1); step();
      idle(1'b1); step();
      drive(1'b1, 2'd0, 3'b010, 5'd3, 1'b0, 32'd0, 1'b0, 1'b1); step();
      drive(1'b0, 2'd0, 3'b000, 5'd0, 1'b1, 32'h33, 1'b0, 1'b1); step();
      idle(1'b1); step();
      idle(1'b1); step();
      check("order_count", got_q.size(), 3);
      if (got_q.size() == 3) begin
         check("order_tag0",  got_q[0].tag,  5'd1);
         check("order_data0", got_q[0].data, 32'h11);
         check("order_tag1",  got_q[1].tag,  5'd2);
         check("order_data1", got_q[1].data, 32'h0);
         check("order_err1",  got_q[1].err,  2'd1);
         check("order_tag2",  got_q[2].tag,  5'd3);
         check("order_data2", got_q[2].data, 32'h33);
      end

      // Backpressure with a full queue.
      drive(1'b1, 2'd0, 3'b010, 5'd7, 1'b0, 32'd0, 1'b0, 1'b0); step();
      drive(1'b1, 2'd0, 3'b010, 5'd8, 1'b0, 32'd0, 1'b0, 1'b0); step();
      drive(1'b0, 2'd0, 3'b000, 5'd0, 1'b1, 32'hA5A5_0001, 1'b0, 1'b0); step();
      drive(1'b0, 2'd0, 3'b000, 5'd0, 1'b1, 32'hA5A5_0002, 1'b0, 1'b0); step();
      check("bp_full_ready", req_ready, 1'b0);
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 2'd0, 3'b010, 5'd9, 1'b0, 32'd0, 1'b0, 1'b0); step();
         check("bp_hold_valid", rsp_valid, 1'b1);
         check("bp_hold_tag",   rsp_tag,   5'd7);
         check("bp_hold_data",  rsp_data,  32'hA5A5_0001);
      end
      idle(1'b1); step();
      check("bp_ready_back", req_ready, 1'b1);
      check("bp_next_tag",   rsp_tag,   5'd8);
      step();
      idle(1'b1); step();

      // Access fault on the second response.
      got_q.delete();
      drive(1'b1, 2'd0, 3'b010, 5'd4, 1'b0, 32'd0, 1'b0, 1'b1); step();
      drive(1'b1, 2'd0, 3'b010, 5'd5, 1'b0, 32'd0, 1'b0, 1'b1); step();
      drive(1'b0, 2'd0, 3'b000, 5'd0, 1'b1, 32'h0000_0044, 1'b0, 1'b1); step();
      drive(1'b0, 2'd0, 3'b000, 5'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1); step();
      idle(1'b1); step();
      idle(1'b1); step();
      check("fault_count", got_q.size(), 2);
      if (got_q.size() == 2) begin
         check("fault_err0",  got_q[0].err,  2'd0);
         check("fault_err1",  got_q[1].err,  2'd3);
         check("fault_data1", got_q[1].data, 32'h0);
         check("fault_tag1",  got_q[1].tag,  5'd5);
      end

      // Reset with two outstanding loads, then a stray response.
      drive(1'b1, 2'd0, 3'b010, 5'd10, 1'b0, 32'd0, 1'b0, 1'b1); step();
      drive(1'b1, 2'd0, 3'b010, 5'd11, 1'b0, 32'd0, 1'b0, 1'b1); step();
      idle(1'b1);
      rst_n = 1'b0;
      #1;
      check("midrst_valid", rsp_valid, 1'b0);
      check("midrst_ready", req_ready, 1'b1);
      mq.delete();
      #2;
      rst_n = 1'b1;
      drive(1'b0, 2'd0, 3'b000, 5'd0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1); step();
      check("stray_valid", rsp_valid, 1'b0);
      check("stray_ready", req_ready, 1'b1);
      load_one("post_rst_lhu", 3'b101, 2'd2, 32'h8001_0000, 32'h0000_8001, 2'd0);

      // Randomized traffic against the model.
      for (int k = 0; k < 400; k++) begin
         drive($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
               TAG_W'($urandom), $urandom_range(0, 2) != 0, $urandom,
               $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
         step();
      end
      for (int k = 0; k < 20 && mq.size() > 0; k++) begin
         drive(1'b0, 2'd0, 3'd0, '0, 1'b1, $urandom, 1'b0, 1'b1);
         step();
      end
      idle(1'b1); step();
      check("drain_valid", rsp_valid, 1'b0);
      check("drain_ready", req_ready, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
